cycle_uart_out: RTL
===================

# cycle_uart_out

Transmit-side companion of the UART word receiver. Accepts full-width words from the core into an internal circular FIFO and breaks each word into WORD_PART-bit parts. Each part is sent as a standard 8N1-style UART frame on a single serial line. It sits directly downstream of the word buffer/processing logic, and drives the line that the receive block and the host terminal sample.

## Interface
- WORD_SIZE, 32, width of one buffered word; must be an integer multiple of WORD_PART
- WORD_PART, 8, data bits per UART frame (one part of a word)
- MEM_SIZE, 64, FIFO depth in words; power of two
- CLKS_PER_BIT, 1736, clock cycles per serial bit (200 MHz / 115200 baud)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low; clears FIFO and aborts any frame
- write_req  in  1  one-cycle strobe; pushes data_in when not full
- data_in  in  WORD_SIZE  word to transmit
- sig  out  1  serial TX line, idle high
- full  out  1  FIFO holds MEM_SIZE words
- empty  out  1  FIFO holds 0 words (the word being shifted out is not counted)
- busy  out  1  a word is being serialised

## Operation
- FIFO: write pointer, read pointer and count, all wrapping modulo MEM_SIZE. Count is clog2(MEM_SIZE)+1 bits wide.
- write_req while full: the word is dropped. Pointers and count are unchanged.
- Push and pop in the same cycle:
  - If the FIFO is full, full is evaluated before the pop, so the write is dropped.
  - Otherwise the count is unchanged and both pointers advance.
- FSM states: IDLE, LOAD, START, DATA, STOP.
- IDLE: sig=1, busy=0. If !empty, go to LOAD.
- LOAD:
  - Pop the head word into the shift register and set part_idx=0.
  - Set busy=1 and go to START.
- START: sig=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA:
  - Drive sig with bit bit_idx of the current part, LSB first, for CLKS_PER_BIT cycles each.
  - After bit WORD_PART-1, go to STOP.
- STOP: sig=1 for CLKS_PER_BIT cycles, then branch:
  - If part_idx < WORD_SIZE/WORD_PART-1: increment part_idx, shift the word right by WORD_PART, go to START. There is no extra idle time between parts.
  - Else if !empty: go to LOAD, for back-to-back words.
  - Else: go to IDLE and clear busy.
- Part order: least-significant part first (bits [WORD_PART-1:0] first).
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state entry. Bit duration is exact, with no drift.

## Timing
- Reset values:
  - sig=1, busy=0, empty=1, full=0.
  - FSM in IDLE; all pointers, counters and the count at 0.
- Reset asserted mid-frame forces sig=1 immediately (asynchronously). Buffered words are lost.
- Flags: empty and full are registered from count, and change on the edge after the push/pop that alters count.
- Write latency, at an accepting edge N into an empty FIFO with FSM in IDLE:
  - empty falls at N+1.
  - LOAD at N+1; the pop makes empty rise at N+2.
  - sig falls at N+2 and busy rises at N+2.
- Frame length: (WORD_PART+2)*CLKS_PER_BIT cycles.
- Word length: (WORD_SIZE/WORD_PART) frames. Back-to-back words insert exactly 1 LOAD cycle of sig=1 after the last stop bit.
- busy falls on the edge after the final stop bit of the last word when the FIFO is empty.

## Test plan
- Reset check (CLKS_PER_BIT=4): hold reset=0 for 3 cycles -> sig=1, busy=0, empty=1, full=0. Release; with no writes, sig stays 1 for 100 cycles.
- Single word: write 0x6C6C6568 -> frames 0x68, 0x65, 0x6C, 0x6C in that order.
  - The first frame bit sequence is 0, 0,0,0,1,0,1,1,0, 1, each bit held exactly 4 cycles.
  - sig falls 2 cycles after the write.
  - busy is high for 160 cycles, then returns to 0.
- Back-to-back: write 0x6C6C6568, then 0x6F77096F, in consecutive cycles.
  - Expect 8 frames decoding to 68 65 6C 6C 6F 09 77 6F.
  - One idle-high cycle between the two words; empty=1 once the second word is loaded.
- Full/overflow: with TX busy, write 64 words (values 0..63) -> full=1 after the 64th. A 65th write of 0xDEADBEEF is dropped.
  - All 65 words decode in order (the one in flight plus 0..63); 0xDEADBEEF never appears.
- Simultaneous push/pop at full: issue write_req in the cycle the FSM pops -> the word is dropped and full stays asserted at the next edge.
  - When not full, the same collision keeps count unchanged and the data is preserved.
- Reset mid-frame: assert reset during the DATA bit 3 of the second part -> sig=1 asynchronously and FIFO empty.
  - After release and a write of 0x00000041, exactly 4 frames 41 00 00 00 follow.

Source files
------------

// File: rtl/cycle_uart_out_if.sv
// cycle_uart_out_if: word write port and FIFO status between the core and the UART transmitter
interface cycle_uart_out_if #(
  parameter int WORD_SIZE = 32
) ();
  logic                 write_req;
  logic [WORD_SIZE-1:0] data_in;
  logic                 full;
  logic                 empty;
  modport master (output write_req, data_in, input full, empty);
  modport slave (input write_req, data_in, output full, empty);
endinterface

// File: rtl/cycle_uart_out.sv
// cycle_uart_out: buffers words in a circular FIFO and sends each one, least-significant part first, as 8N1 UART frames
module cycle_uart_out #(
  parameter int WORD_SIZE    = 32,
  parameter int WORD_PART    = 8,
  parameter int MEM_SIZE     = 64,
  parameter int CLKS_PER_BIT = 1736
) (
  input  logic            clock,
  input  logic            reset,
  cycle_uart_out_if.slave bus,
  output logic            sig,
  output logic            busy
);
  localparam int PARTS = WORD_SIZE / WORD_PART;
  localparam int AW = $clog2(MEM_SIZE);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = WORD_PART > 1 ? $clog2(WORD_PART) : 1;
  localparam int PW = PARTS > 1 ? $clog2(PARTS) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(WORD_PART - 1);
  localparam logic [PW-1:0] PART_MAX = PW'(PARTS - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(MEM_SIZE);
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] mem [MEM_SIZE];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [WORD_SIZE-1:0] shreg;
  logic [WORD_PART-1:0] cur_part;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx, bit_nxt;
  logic [PW-1:0]        part_idx;
  logic                 full_q, empty_q;
  logic                 baud_done, last_part, have_word, push, pop, next_part;

  assign bus.full = full_q;
  assign bus.empty = empty_q;
  assign cur_part = shreg[WORD_PART-1:0];

  // The FSM looks at the live count rather than the registered flag so a word
  // written into an idle transmitter is popped on the very next edge.
  always_comb begin
    baud_done = baud_cnt == BAUD_MAX;
    last_part = part_idx == PART_MAX;
    have_word = count != '0;
    push = bus.write_req && count != DEPTH;
    next_part = state == STOP && baud_done && !last_part;
    bit_nxt = state == DATA ? bit_idx + BW'(baud_done) : '0;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = have_word ? LOAD : IDLE;
      LOAD:    state_nxt = START;
      START:   state_nxt = baud_done ? DATA : START;
      DATA:    state_nxt = (baud_done && bit_idx == BIT_MAX) ? STOP : DATA;
      STOP:    state_nxt = !baud_done ? STOP : !last_part ? START : have_word ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
    pop = state_nxt == LOAD;
  end

  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= bus.data_in;

  // Full is judged on the count before any same-cycle pop, so a collision at full drops the write.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push);
      rd_ptr  <= rd_ptr + AW'(pop);
      count   <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      full_q  <= count == DEPTH;
      empty_q <= count == '0;
    end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      part_idx <= '0;
      shreg    <= '0;
      sig      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= (state_nxt != state || baud_done) ? '0 : baud_cnt + 1'b1;
      bit_idx  <= bit_nxt;
      part_idx <= pop ? '0 : part_idx + PW'(next_part);
      shreg    <= pop ? mem[rd_ptr] : next_part ? shreg >> WORD_PART : shreg;
      sig      <= state_nxt == START ? 1'b0 : state_nxt == DATA ? cur_part[bit_nxt] : 1'b1;
      busy     <= state_nxt == START ? 1'b1 : state_nxt == IDLE ? 1'b0 : busy;
    end
endmodule
